// File: rtl/add_sequencer.sv
// Multi-word add/subtract: streams WORDS 9-bit words LSW-first through one shared adder, carry registered between words.
// Latency: WORDS+1 cycles from accepted start to the done pulse; one operation per WORDS+2 cycles.
// Backpressure: none queued; start is only honoured in IDLE and dropped while RUN or DONE.

module carry_lookahead_adder (
    input  logic [8:0] x,
    input  logic [8:0] y,
    input  logic       carry_in,
    output logic [8:0] z,
    output logic       carry_out
);
    logic [8:0] g;
    logic [8:0] p;
    logic [9:0] c;

    assign g = x & y;
    assign p = x ^ y;

    // Carries written as the generate/propagate recurrence; synthesis flattens it into lookahead terms.
    always_comb begin
        c    = '0;
        c[0] = carry_in;
        for (int i = 0; i < 9; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign z         = p ^ c[8:0];
    assign carry_out = c[9];
endmodule

module add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sub,
    input  logic               cin,
    input  logic [9*WORDS-1:0] a,
    input  logic [9*WORDS-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [9*WORDS-1:0] sum,
    output logic               cout
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WORDS-1:0][8:0] a_q;
    logic [WORDS-1:0][8:0] b_q;
    logic [WORDS-1:0][8:0] sum_q;
    logic                  carry_q;
    logic                  cout_q;
    logic [IW-1:0]         idx_q;

    logic                  accept;
    logic                  last_word;
    logic [8:0]            add_z;
    logic                  add_co;

    assign last_word = (idx_q == IW'(WORDS - 1));

    carry_lookahead_adder u_adder (
        .x         (a_q[idx_q]),
        .y         (b_q[idx_q]),
        .carry_in  (carry_q),
        .z         (add_z),
        .carry_out (add_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtract is a + ~b + 1, so the operand is inverted once at latch time and the initial carry forced high.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            idx_q   <= '0;
        end else if (state == RUN) begin
            sum_q[idx_q] <= add_z;
            carry_q      <= add_co;
            idx_q        <= idx_q + IW'(1);
            if (last_word) begin
                cout_q <= add_co;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_add_sequencer.sv
// Randomised and directed bench for add_sequencer (WORDS=4 and WORDS=1) against a plain-arithmetic model.
module tb_add_sequencer;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, sub, cin;
    logic [35:0] a, b;
    logic        busy, done;
    logic [35:0] sum;
    logic        cout;

    logic        start1, sub1, cin1;
    logic [8:0]  a1, b1;
    logic        busy1, done1;
    logic [8:0]  sum1;
    logic        cout1;

    int n_checks = 0;
    int n_fail   = 0;

    add_sequencer #(.WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    add_sequencer #(.WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .cin(cin1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    // Unsigned result with carry: a + b + cin, or a - b as a + ~b + 1.
    function automatic logic [36:0] ref36(input logic [35:0] ra, input logic [35:0] rb,
                                          input logic rs, input logic rc);
        logic [36:0] opb;
        opb = rs ? {1'b0, ~rb} : {1'b0, rb};
        return {1'b0, ra} + opb + 37'(rs ? 1'b1 : rc);
    endfunction

    function automatic logic [9:0] ref9(input logic [8:0] ra, input logic [8:0] rb,
                                        input logic rs, input logic rc);
        logic [9:0] opb;
        opb = rs ? {1'b0, ~rb} : {1'b0, rb};
        return {1'b0, ra} + opb + 10'(rs ? 1'b1 : rc);
    endfunction

    function automatic logic [35:0] rnd36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    // Issues one start on the WORDS=4 instance and observes 8 following cycles; inputs are scrambled after the start.
    task automatic drive_op(input logic [35:0] ta, input logic [35:0] tb, input logic ts, input logic tc,
                            output int busy_cnt, output int done_at, output int done_cnt);
        busy_cnt = 0;
        done_at  = -1;
        done_cnt = 0;
        @(negedge clk);
        a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            a = rnd36(); b = rnd36(); sub = 1'($urandom); cin = 1'($urandom);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, sum, cout} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_w4: busy=%b done=%b sum=%h cout=%b, expected all zero", busy, done, sum, cout);
        end
        n_checks++;
        if ({busy1, done1, sum1, cout1} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_w1: busy=%b done=%b sum=%h cout=%b, expected all zero", busy1, done1, sum1, cout1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        int bc, da, dc;
        drive_op(36'd3, 36'd5, 1'b0, 1'b0, bc, da, dc);
        n_checks++;
        if (bc !== 4) begin n_fail++; $display("FAIL add_busy_cycles: got %0d expected 4", bc); end
        n_checks++;
        if (da !== 5) begin n_fail++; $display("FAIL add_done_latency: got %0d expected 5", da); end
        n_checks++;
        if (dc !== 1) begin n_fail++; $display("FAIL add_done_count: got %0d expected 1", dc); end
        n_checks++;
        if (sum !== 36'd8 || cout !== 1'b0) begin
            n_fail++; $display("FAIL add_result: got sum=%h cout=%b expected sum=8 cout=0", sum, cout);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (sum !== 36'd8 || cout !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL add_hold_idle: got sum=%h cout=%b busy=%b expected 8/0/0", sum, cout, busy);
        end
    endtask

    task automatic test_ripple();
        int bc, da, dc;
        drive_op(36'hF_FFFF_FFFF, 36'd0, 1'b0, 1'b1, bc, da, dc);
        n_checks++;
        if (sum !== 36'd0 || cout !== 1'b1) begin
            n_fail++; $display("FAIL ripple_result: got sum=%h cout=%b expected sum=0 cout=1", sum, cout);
        end
    endtask

    task automatic test_sub();
        int bc, da, dc;
        drive_op(36'd5, 36'd3, 1'b1, 1'b0, bc, da, dc);
        n_checks++;
        if (sum !== 36'd2 || cout !== 1'b1) begin
            n_fail++; $display("FAIL sub_5_3: got sum=%h cout=%b expected sum=2 cout=1", sum, cout);
        end
        drive_op(36'd3, 36'd5, 1'b1, 1'b1, bc, da, dc);
        n_checks++;
        if (sum !== 36'hF_FFFF_FFFE || cout !== 1'b0) begin
            n_fail++; $display("FAIL sub_3_5: got sum=%h cout=%b expected sum=ffffffffe cout=0", sum, cout);
        end
    endtask

    task automatic test_start_ignored();
        logic [36:0] exp;
        int          dc, late_busy;
        dc = 0; late_busy = 0;
        @(negedge clk);
        a = 36'h1_2345_6789; b = 36'h0_0FED_CBA9; sub = 1'b0; cin = 1'b0; start = 1'b1;
        exp = ref36(a, b, sub, cin);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2 || k == 5) begin
                start = 1'b1; a = rnd36(); b = rnd36(); sub = 1'($urandom); cin = 1'($urandom);
            end
            if (done) dc++;
            if (k >= 7 && busy) late_busy++;
        end
        n_checks++;
        if (dc !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", dc); end
        n_checks++;
        if (late_busy !== 0) begin n_fail++; $display("FAIL ignore_late_busy: got %0d busy cycles expected 0", late_busy); end
        n_checks++;
        if ({cout, sum} !== exp) begin
            n_fail++; $display("FAIL ignore_result: got %h expected %h", {cout, sum}, exp);
        end
    endtask

    task automatic test_random();
        logic [35:0] ra, rb;
        logic        rs, rc;
        logic [36:0] exp;
        int          bc, da, dc, bad;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            ra = rnd36(); rb = rnd36(); rs = 1'($urandom); rc = 1'($urandom);
            if (i == 0) rb = ra;
            exp = ref36(ra, rb, rs, rc);
            drive_op(ra, rb, rs, rc, bc, da, dc);
            n_checks++;
            if ({cout, sum} !== exp || bc !== 4 || da !== 5 || dc !== 1) begin
                n_fail++;
                $display("FAIL random_op%0d: got %h busy=%0d done_at=%0d dones=%0d expected %h 4/5/1",
                         i, {cout, sum}, bc, da, dc, exp);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int bc, da, dc;
        dc = 0;
        @(negedge clk);
        a = rnd36() | 36'h1_0000_0001; b = rnd36(); sub = 1'b0; cin = 1'b1; start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2) rst = 1'b1;
            if (k == 3) begin
                rst = 1'b0;
                n_checks++;
                if ({busy, done, sum, cout} !== 39'd0) begin
                    n_fail++;
                    $display("FAIL midrun_reset_state: busy=%b done=%b sum=%h cout=%b expected all zero",
                             busy, done, sum, cout);
                end
            end
            if (k >= 3 && done) dc++;
        end
        n_checks++;
        if (dc !== 0) begin n_fail++; $display("FAIL midrun_no_done: got %0d done pulses expected 0", dc); end
        drive_op(36'h1FF, 36'd1, 1'b0, 1'b0, bc, da, dc);
        n_checks++;
        if (sum !== 36'h200 || cout !== 1'b0 || da !== 5) begin
            n_fail++; $display("FAIL midrun_restart: got sum=%h cout=%b done_at=%0d expected 200/0/5", sum, cout, da);
        end
    endtask

    task automatic test_words1();
        logic [8:0] ra, rb;
        logic       rs, rc;
        logic [9:0] exp;
        int         bc, da;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin ra = 9'h1FF; rb = 9'h001; rs = 1'b0; rc = 1'b0; end
            else begin ra = 9'($urandom); rb = 9'($urandom); rs = 1'($urandom); rc = 1'($urandom); end
            exp = ref9(ra, rb, rs, rc);
            bc = 0; da = -1;
            @(negedge clk);
            a1 = ra; b1 = rb; sub1 = rs; cin1 = rc; start1 = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                start1 = 1'b0;
                a1 = 9'($urandom); b1 = 9'($urandom);
                if (busy1) bc++;
                if (done1 && da < 0) da = k;
            end
            n_checks++;
            if ({cout1, sum1} !== exp || bc !== 1 || da !== 2) begin
                n_fail++;
                $display("FAIL words1_op%0d: got %h busy=%0d done_at=%0d expected %h 1/2",
                         i, {cout1, sum1}, bc, da, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ripple();
        test_sub();
        test_start_ignored();
        test_random();
        test_reset_mid_run();
        test_words1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
